// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed on-chip array behind the CPU data port.
// Latency: LATENCY+1 cycles from accepted request to dmem_ready; errors answer in 1 cycle.
// Backpressure: combinational dmem_stall holds the CPU while a legal access is pending.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] w_data,
  input  logic        dmem_w,
  input  logic        dmem_r,
  output logic [31:0] dmem_data,
  output logic        dmem_ready,
  output logic        dmem_stall,
  output logic        addr_err
);

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdat_q, wdat_d;
  logic              we_q, we_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic [31:0]       mem [2**ADDR_W];

  logic              req;
  logic              legal;
  logic [ADDR_W-1:0] in_idx;
  logic              commit;
  logic              mem_we;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       acc_wdat;
  logic              acc_we;
  logic              unused_addr_hi;

  assign req    = dmem_r | dmem_w;
  assign legal  = (data_addr[1:0] == 2'b00) && !(dmem_r && dmem_w);
  assign in_idx = data_addr[ADDR_W+1:2];

  // Upper address bits alias onto the array and are deliberately dropped.
  assign unused_addr_hi = ^data_addr[31:ADDR_W+2];

  // Next-state, request latching and the commit strobe for the edge entering DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdat_d   = wdat_q;
    we_d     = we_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    commit   = 1'b0;
    acc_idx  = idx_q;
    acc_wdat = wdat_q;
    acc_we   = we_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (!legal) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d  = in_idx;
            wdat_d = w_data;
            we_d   = dmem_w;
            cnt_d  = LAT4;
            if (LATENCY == 0) begin
              // Zero wait states: the access happens on this very edge, so use the live inputs.
              state_d  = S_DONE;
              commit   = 1'b1;
              ready_d  = 1'b1;
              acc_idx  = in_idx;
              acc_wdat = w_data;
              acc_we   = dmem_w;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_DONE;
          commit  = 1'b1;
          ready_d = 1'b1;
        end
      end
      S_DONE: begin
        // The CPU still holds the finished request here; never re-accept it.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    rdata_d = (commit && !acc_we) ? mem[acc_idx] : rdata_q;
  end

  // Writes are gated by reset so an aborted access can never land in the array.
  assign mem_we = commit && acc_we && rst;

  // Control and output registers; the array itself is never cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdat_q  <= 32'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdat;
    end
  end

  assign dmem_data  = rdata_q;
  assign dmem_ready = ready_q;
  assign addr_err   = err_q;
  assign dmem_stall = rst && (((state_q == S_IDLE) && req && legal) || (state_q == S_WAIT));

endmodule
